als_sample_filter: RTL and testbench
====================================

# als_sample_filter

Averaging and hand-off stage between the SPI receiver and the binary-to-BCD converter in the Pmod ALS display path. It edge-detects the receiver's data-valid strobe and accumulates 2^LOG2_N light samples. It delivers the truncated average to the double-dabble converter with a one-cycle start pulse, then waits for the converter's done strobe. This replaces ad-hoc strobe-driven start logic with a single-clock, reset-safe handshake and one-deep result buffering.

## Interface
- DATA_W, 8, sample and average width
- LOG2_N, 3, log2 of samples per averaging window (window = 2^LOG2_N samples)
- TIMEOUT_CYC, 1024, cycles to wait for converter done before abandoning (used only with timeout feature)
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- i_rx_byte  input  DATA_W  sample from SPI receiver; valid when i_rx_dv rises
- i_rx_dv  input  1  receiver data-valid; level or pulse, rising edge accepted
- o_binary  output  DATA_W  average presented to converter; stable from o_start until next launch
- o_start  output  1  one-cycle launch pulse to converter
- i_conv_dv  input  1  converter done strobe
- o_busy  output  1  high in START and WAIT
- o_overrun  output  1  sticky: a completed average was overwritten unconsumed
- o_timeout  output  1  sticky: converter failed to respond (timeout build only; else tied 0)

## Operation
- Reset (async assert, sync release): state ACCUM, accumulator 0, sample count 0, pending empty; o_binary=0, o_start=0, o_busy=0, o_overrun=0, o_timeout=0.
- Edge detect: register prev i_rx_dv (reset 0). A sample is accepted on any clk edge where i_rx_dv=1 and prev=0. Holding i_rx_dv high counts once.
- Accumulator width: DATA_W+LOG2_N, unsigned, never overflows. Count width: LOG2_N+1.
- Accumulation runs in every state. On accepting the 2^LOG2_N-th sample:
  - window result = (acc + sample) >> LOG2_N (truncate);
  - acc and count clear to 0 on the same edge.
- States:
  - ACCUM: window completes -> load o_binary with result, go START. Pending valid -> load o_binary from pending, clear pending, go START.
  - START: o_start=1 for exactly this cycle; go WAIT.
  - WAIT: i_conv_dv=1 -> pending valid or window completing this edge -> load that value (window result wins if both; o_overrun set), go START; otherwise go ACCUM.
- A window completing in START or WAIT (not consumed that edge) writes the pending register. If pending was already valid, overwrite it and set o_overrun.
- i_conv_dv outside WAIT is ignored.
- o_busy = (state==START)|(state==WAIT).

## Timing
- Sample accepted on edge E (i_rx_dv first sampled high). Count/acc visible from E.
- Final sample accepted on edge E: o_binary valid and state START after E; o_start high for cycle E..E+1; WAIT from E+1.
- i_conv_dv high at edge D in WAIT with pending: o_start high again in cycle after D (back-to-back, no idle cycle).
- Minimum spacing between o_start pulses: 2 cycles.
- rst_n assertion mid-window or mid-WAIT: immediate clear; partial sums discarded; no o_start until a fresh full window.

## Configuration
- ALS_FILTER_TIMEOUT_EN defined:
  - WAIT has a cycle counter cleared on entry.
  - If TIMEOUT_CYC cycles elapse without i_conv_dv, set o_timeout and leave WAIT: go START with pending if valid, else ACCUM.
  - i_conv_dv on the expiry cycle takes priority (no timeout flagged).
- ALS_FILTER_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; o_timeout constant 0.

## Test plan
- LOG2_N=3, eight samples of 100 -> o_binary=100 and exactly one o_start pulse, one cycle after the 8th accepted edge; o_busy high until i_conv_dv.
- Samples 0..7 -> sum 28, o_binary=3 (truncation). Eight samples of 255 -> o_binary=255 (no overflow).
- i_rx_dv held high 5 cycles per sample, 8 such pulses -> exactly 8 samples counted, one launch.
- Converter stalled (i_conv_dv low) across two further full windows of 10 then 20 -> o_overrun=1. On i_conv_dv, o_start in the next cycle with o_binary=20.
- rst_n pulsed low after 5 of 8 samples -> all outputs 0. Next launch only after 8 new samples, average from post-reset data only.
- ALS_FILTER_TIMEOUT_EN, TIMEOUT_CYC=16, no i_conv_dv -> o_timeout=1 after 16 WAIT cycles, state ACCUM, o_busy=0. Without the macro, o_busy stays 1.

Source files
------------

// File: rtl/als_sample_filter_if.sv
// Handshake bundle between the SPI receiver, the sample filter and the
// binary-to-BCD converter.
//   slave  : filter side (receives samples and converter done, drives launch/status)
//   master : environment side (receiver + converter model)
// Signals:
//   i_rx_byte / i_rx_dv : sample and its data-valid strobe from the SPI receiver
//   o_binary / o_start  : averaged value and one-cycle launch pulse to the converter
//   i_conv_dv           : converter done strobe
//   o_busy              : launch or wait for converter in progress
//   o_overrun           : sticky, an unconsumed average was overwritten
//   o_timeout           : sticky, converter did not answer (timeout build only)
interface als_sample_filter_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] i_rx_byte;
  logic              i_rx_dv;
  logic [DATA_W-1:0] o_binary;
  logic              o_start;
  logic              i_conv_dv;
  logic              o_busy;
  logic              o_overrun;
  logic              o_timeout;

  modport slave (
    input  i_rx_byte,
    input  i_rx_dv,
    input  i_conv_dv,
    output o_binary,
    output o_start,
    output o_busy,
    output o_overrun,
    output o_timeout
  );

  modport master (
    output i_rx_byte,
    output i_rx_dv,
    output i_conv_dv,
    input  o_binary,
    input  o_start,
    input  o_busy,
    input  o_overrun,
    input  o_timeout
  );
endinterface

// File: rtl/als_sample_filter.sv
// Averaging and hand-off stage for the Pmod ALS display path.
// Edge-detects the receiver data-valid strobe, sums 2^LOG2_N samples and hands the
// truncated average to the double-dabble converter with a one-cycle start pulse,
// then waits for the converter's done strobe. One completed average can be held
// while the converter is busy; overwriting it raises the sticky overrun flag.
// Optional feature macro: ALS_FILTER_TIMEOUT_EN -- abandon the wait for the
// converter after TIMEOUT_CYC cycles and raise the sticky timeout flag.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : als_sample_filter_if.slave (sample input, converter handshake, status)
module als_sample_filter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LOG2_N      = 3,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                clk,
  input logic                rst_n,
  als_sample_filter_if.slave bus
);

  localparam int unsigned AccW = DATA_W + LOG2_N;
  localparam int unsigned CntW = LOG2_N + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((1 << LOG2_N) - 1);

  typedef enum logic [1:0] {StAccum, StStart, StWait} state_e;

  state_e            state_q, state_d;
  logic              prev_dv_q;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] binary_q, binary_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              win_done;
  logic [AccW-1:0]   sum;
  logic [DATA_W-1:0] win_avg;
  logic              to_expire;
  logic              take;

  // Rising edge of the receiver strobe; a held-high strobe counts once.
  assign accept   = bus.i_rx_dv & ~prev_dv_q;
  // AccW bits hold 2^LOG2_N full-scale samples, so this never wraps.
  assign sum      = acc_q + AccW'(bus.i_rx_byte);
  assign win_done = accept & (cnt_q == LastCnt);
  assign win_avg  = DATA_W'(sum >> LOG2_N);

  // Accumulation is independent of the hand-off state.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (win_done) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + CntW'(1);
    end
  end

`ifdef ALS_FILTER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q, timeout_d;

  // WAIT is only entered from START, where the counter is held at zero.
  assign to_expire = (state_q == StWait) && (to_cnt_q == ToLast);

  always_comb begin
    to_cnt_d  = (state_q == StWait) ? to_cnt_q + ToW'(1) : '0;
    // A done strobe on the expiry cycle wins over the timeout.
    timeout_d = timeout_q | (to_expire & ~bus.i_conv_dv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign to_expire          = 1'b0;
  assign bus.o_timeout      = 1'b0;
`endif

  // take: this edge may hand a value to the converter (idle, or the converter
  // just finished / was abandoned).
  always_comb begin
    state_d    = state_q;
    binary_d   = binary_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = overrun_q;
    take       = (state_q == StAccum) ||
                 ((state_q == StWait) && (bus.i_conv_dv || to_expire));

    if (state_q == StStart) begin
      state_d = StWait;
    end else if (take) begin
      if (win_done) begin
        // Fresh window beats a held one; the held one is lost.
        binary_d = win_avg;
        state_d  = StStart;
        if (pend_vld_q) begin
          pend_vld_d = 1'b0;
          overrun_d  = 1'b1;
        end
      end else if (pend_vld_q) begin
        binary_d   = pend_q;
        pend_vld_d = 1'b0;
        state_d    = StStart;
      end else begin
        state_d = StAccum;
      end
    end

    if (win_done && !take) begin
      pend_d     = win_avg;
      pend_vld_d = 1'b1;
      if (pend_vld_q) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAccum;
      prev_dv_q  <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      binary_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_dv_q  <= bus.i_rx_dv;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      binary_q   <= binary_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.o_binary  = binary_q;
  assign bus.o_start   = (state_q == StStart);
  assign bus.o_busy    = (state_q == StStart) || (state_q == StWait);
  assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_als_sample_filter.sv
module tb_als_sample_filter;
  localparam int unsigned DW  = 8;
  localparam int unsigned L2N = 3;
  localparam int unsigned TO  = 16;
  localparam int          N   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  als_sample_filter_if #(.DATA_W(DW)) bus ();

  als_sample_filter #(
    .DATA_W     (DW),
    .LOG2_N     (L2N),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int bad    = 0;
  int starts = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a list of accepted samples per window, at most one held
  // average, and flags for "launching" and "converter owes a done".
  bit m_prev, m_launch, m_await, m_pvld, m_over, m_to;
  int m_bin, m_pend, m_wait;
  int m_win[$];

  task automatic model_reset();
    m_prev = 0; m_launch = 0; m_await = 0; m_pvld = 0; m_over = 0; m_to = 0;
    m_bin = 0; m_pend = 0; m_wait = 0;
    m_win.delete();
  endtask

  task automatic stash(input int v);
    if (m_pvld) m_over = 1;
    m_pend = v;
    m_pvld = 1;
  endtask

  task automatic model_step(input bit dv, input int b, input bit conv);
    bit done;
    bit handoff;
    int avg;
    done = 0;
    avg  = 0;
    if (dv && !m_prev) begin
      m_win.push_back(b);
      if (m_win.size() == N) begin
        avg  = m_win.sum() / N;
        done = 1;
        m_win.delete();
      end
    end
    m_prev = dv;
    if (m_launch) begin
      m_launch = 0;
      m_await  = 1;
      m_wait   = 0;
      if (done) stash(avg);
    end else begin
      handoff = !m_await;
      if (m_await) begin
        if (conv) handoff = 1;
`ifdef ALS_FILTER_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TO) begin
            handoff = 1;
            m_to    = 1;
          end
        end
`endif
      end
      if (handoff) begin
        m_await = 0;
        if (done) begin
          if (m_pvld) begin
            m_over = 1;
            m_pvld = 0;
          end
          m_bin    = avg;
          m_launch = 1;
        end else if (m_pvld) begin
          m_bin    = m_pend;
          m_pvld   = 0;
          m_launch = 1;
        end
      end else if (done) begin
        stash(avg);
      end
    end
  endtask

  // Per-cycle comparison, #1 after each rising edge; inputs change only on falling edges.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else model_step(bus.i_rx_dv, int'(bus.i_rx_byte), bus.i_conv_dv);
      if (bus.o_start) starts++;
      chk("start",   int'(bus.o_start),   int'(m_launch));
      chk("busy",    int'(bus.o_busy),    int'(m_launch | m_await));
      chk("binary",  int'(bus.o_binary),  m_bin);
      chk("overrun", int'(bus.o_overrun), int'(m_over));
      chk("timeout", int'(bus.o_timeout), int'(m_to));
    end
  end

  task automatic sample(input int v, input int hold);
    @(negedge clk);
    bus.i_rx_byte = DW'(v);
    bus.i_rx_dv   = 1'b1;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    bus.i_rx_dv = 1'b0;
  endtask

  task automatic window(input int base, input int step, input int hold);
    for (int i = 0; i < N; i++) sample(base + i * step, hold);
  endtask

  task automatic conv();
    @(negedge clk);
    bus.i_conv_dv = 1'b1;
    @(negedge clk);
    bus.i_conv_dv = 1'b0;
  endtask

  int s0;

  initial begin
    bus.i_rx_byte = '0;
    bus.i_rx_dv   = 1'b0;
    bus.i_conv_dv = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_binary", int'(bus.o_binary), 0);
    chk("rst_busy",   int'(bus.o_busy),   0);
    chk("rst_start",  int'(bus.o_start),  0);
    rst_n = 1'b1;

    // Eight samples of 100.
    s0 = starts;
    window(100, 0, 1);
    chk("avg100",          int'(bus.o_binary), 100);
    chk("start_after_8th", int'(bus.o_start),  1);
    repeat (4) @(negedge clk);
    chk("one_launch_100", starts - s0, 1);
    chk("busy_in_wait",   int'(bus.o_busy), 1);
    conv();
    @(negedge clk);
    chk("idle_after_done", int'(bus.o_busy), 0);

    // 0..7 truncates 28/8 to 3; full scale does not overflow.
    window(0, 1, 1);
    chk("avg_trunc", int'(bus.o_binary), 3);
    conv();
    window(255, 0, 1);
    chk("avg255", int'(bus.o_binary), 255);
    conv();

    // Strobe held 5 cycles per sample: 8,16..64 -> 288/8 = 36.
    s0 = starts;
    window(8, 8, 5);
    chk("held_avg", int'(bus.o_binary), 36);
    repeat (3) @(negedge clk);
    chk("held_one_launch", starts - s0, 1);
    chk("no_overrun_yet",  int'(bus.o_overrun), 0);
    conv();

    // Stalled converter across two further windows.
    window(100, 0, 1);
    window(10, 0, 1);
`ifndef ALS_FILTER_TIMEOUT_EN
    chk("pending_no_overrun", int'(bus.o_overrun), 0);
`endif
    window(20, 0, 1);
`ifndef ALS_FILTER_TIMEOUT_EN
    chk("overrun_set",   int'(bus.o_overrun), 1);
    chk("binary_stable", int'(bus.o_binary),  100);
`endif
    @(negedge clk);
    bus.i_conv_dv = 1'b1;
    @(negedge clk);
    bus.i_conv_dv = 1'b0;
`ifndef ALS_FILTER_TIMEOUT_EN
    chk("backtoback_start", int'(bus.o_start),  1);
    chk("backtoback_bin",   int'(bus.o_binary), 20);
`endif
    repeat (3) @(negedge clk);
    conv();
    @(negedge clk);
    chk("idle_after_overrun", int'(bus.o_busy), 0);

    // Reset mid-window discards the partial sum.
    for (int i = 0; i < 5; i++) sample(200, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_binary",  int'(bus.o_binary),  0);
    chk("midrst_overrun", int'(bus.o_overrun), 0);
    chk("midrst_busy",    int'(bus.o_busy),    0);
    chk("midrst_start",   int'(bus.o_start),   0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = starts;
    for (int i = 0; i < N - 1; i++) sample(60 + 2 * i, 1);
    chk("no_early_launch", starts - s0, 0);
    sample(60 + 2 * (N - 1), 1);
    chk("post_rst_avg",   int'(bus.o_binary), 67);
    chk("post_rst_start", int'(bus.o_start),  1);

    // Converter never answers.
    repeat (TO + 4) @(negedge clk);
`ifdef ALS_FILTER_TIMEOUT_EN
    chk("timeout_flag", int'(bus.o_timeout), 1);
    chk("timeout_idle", int'(bus.o_busy),    0);
`else
    chk("hold_busy",  int'(bus.o_busy),    1);
    chk("no_timeout", int'(bus.o_timeout), 0);
`endif
    conv();
    repeat (3) @(negedge clk);
    chk("final_idle", int'(bus.o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
